// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap controller: FSM encodings, CSR addresses, cause codes and
// mstatus bit positions.
package trap_ctrl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_W_MEPC    = 3'd1;
    localparam logic [2:0] ST_W_MSTATUS = 3'd2;
    localparam logic [2:0] ST_W_MCAUSE  = 3'd3;
    localparam logic [2:0] ST_ASSERT    = 3'd4;
    localparam logic [2:0] ST_R_MSTATUS = 3'd5;
    localparam logic [2:0] ST_R_ASSERT  = 3'd6;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/trap_vec_calc.sv
// Redirect target for trap entry. With TRAP_CTRL_VECTORED_EN defined, interrupts taken with
// mtvec mode 01 jump to base + 4*cause; everything else goes to the base address.
module trap_vec_calc #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_mtvec,
    input  logic [DATA_W-1:0] i_cause,
    output logic [ADDR_W-1:0] o_target
);

    logic [ADDR_W-1:0] w_base;
    assign w_base = {i_mtvec[ADDR_W-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
    logic              w_vectored;
    logic [ADDR_W-1:0] w_offset;
    logic              w_unused;

    assign w_vectored = (i_mtvec[1:0] == 2'b01) && i_cause[DATA_W-1];
    assign w_offset   = {i_cause[ADDR_W-3:0], 2'b00};
    assign w_unused   = ^i_cause[DATA_W-2:ADDR_W-2];
    assign o_target   = w_vectored ? (w_base + w_offset) : w_base;
`else
    logic w_unused;

    assign w_unused = ^{i_mtvec[1:0], i_cause};
    assign o_target = w_base;
`endif

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt controller: sequences mepc/mstatus/mcause writes on trap entry, mstatus
// restore on mret, and redirects fetch. Optional vectored mode: TRAP_CTRL_VECTORED_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned INT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INT_W-1:0]  int_flag_i,
    input  logic              ecall_i,
    input  logic              ebreak_i,
    input  logic              mret_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ex_csr_we_i,
    input  logic [DATA_W-1:0] csr_mtvec_i,
    input  logic [DATA_W-1:0] csr_mepc_i,
    input  logic [DATA_W-1:0] csr_mstatus_i,
    input  logic              global_int_en_i,
    output logic              hold_o,
    output logic              csr_we_o,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              int_assert_o,
    output logic [ADDR_W-1:0] int_addr_o
);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_epc;
    logic [DATA_W-1:0] r_cause;

    logic [2:0]        w_state_d;
    logic [ADDR_W-1:0] w_epc_d;
    logic [DATA_W-1:0] w_cause_d;
    logic              w_trap_sync;
    logic              w_int_req;
    logic [ADDR_W-1:0] w_trap_target;

    assign w_trap_sync = ecall_i | ebreak_i;
    assign w_int_req   = global_int_en_i & (|int_flag_i);

    trap_vec_calc #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_vec_calc (
        .i_mtvec  (csr_mtvec_i),
        .i_cause  (r_cause),
        .o_target (w_trap_target)
    );

    always_comb begin
        w_state_d = r_state;
        w_epc_d   = r_epc;
        w_cause_d = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (w_trap_sync) begin
                    w_epc_d   = inst_addr_i;
                    w_cause_d = ecall_i ? DATA_W'(CAUSE_ECALL) : DATA_W'(CAUSE_EBREAK);
                    w_state_d = ST_W_MEPC;
                end else if (mret_i) begin
                    w_state_d = ST_R_MSTATUS;
                end else if (w_int_req) begin
                    w_epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
                    w_cause_d = DATA_W'(CAUSE_EXT_INT);
                    w_state_d = ST_W_MEPC;
                end
            end
            // A concurrent EX CSR write wins in csr_reg, so the write state is retried.
            ST_W_MEPC:    if (!ex_csr_we_i) w_state_d = ST_W_MSTATUS;
            ST_W_MSTATUS: if (!ex_csr_we_i) w_state_d = ST_W_MCAUSE;
            ST_W_MCAUSE:  if (!ex_csr_we_i) w_state_d = ST_ASSERT;
            ST_R_MSTATUS: if (!ex_csr_we_i) w_state_d = ST_R_ASSERT;
            default:      w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_o       = 1'b0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: hold_o = w_trap_sync | mret_i | w_int_req;
                ST_W_MEPC: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = ADDR_W'(CSR_MEPC);
                    csr_wdata_o = DATA_W'(r_epc);
                end
                ST_W_MSTATUS: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = ADDR_W'(CSR_MSTATUS);
                    csr_wdata_o = csr_mstatus_i;
                    csr_wdata_o[MSTATUS_MPIE_BIT] = csr_mstatus_i[MSTATUS_MIE_BIT];
                    csr_wdata_o[MSTATUS_MIE_BIT]  = 1'b0;
                end
                ST_W_MCAUSE: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = ADDR_W'(CSR_MCAUSE);
                    csr_wdata_o = r_cause;
                end
                ST_ASSERT: begin
                    hold_o       = 1'b1;
                    int_assert_o = 1'b1;
                    int_addr_o   = w_trap_target;
                end
                ST_R_MSTATUS: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = ADDR_W'(CSR_MSTATUS);
                    csr_wdata_o = csr_mstatus_i;
                    csr_wdata_o[MSTATUS_MIE_BIT]  = csr_mstatus_i[MSTATUS_MPIE_BIT];
                    csr_wdata_o[MSTATUS_MPIE_BIT] = 1'b1;
                end
                ST_R_ASSERT: begin
                    hold_o       = 1'b1;
                    int_assert_o = 1'b1;
                    int_addr_o   = ADDR_W'(csr_mepc_i);
                end
                default: hold_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_epc   <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_state_d;
            r_epc   <= w_epc_d;
            r_cause <= w_cause_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed literal checks followed by randomized stimulus
// compared every cycle against a queue-based model of the trap/mret write sequences.
module tb_trap_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int INT_W  = 8;

    localparam int K_MEPC  = 0;
    localparam int K_MST_T = 1;
    localparam int K_MCAUS = 2;
    localparam int K_AS_T  = 3;
    localparam int K_MST_R = 4;
    localparam int K_AS_R  = 5;

    logic              clk;
    logic              rst;
    logic [INT_W-1:0]  int_flag_i;
    logic              ecall_i, ebreak_i, mret_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              ex_csr_we_i;
    logic [DATA_W-1:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic              global_int_en_i;
    logic              hold_o, csr_we_o, int_assert_o;
    logic [ADDR_W-1:0] csr_waddr_o, int_addr_o;
    logic [DATA_W-1:0] csr_wdata_o;

    // CSR file as seen by the controller; updated by the model's expected writes.
    logic [31:0] m_mtvec, m_mepc, m_mstatus;
    logic [31:0] m_epc, m_cause;
    int          q[$];
    int          n_cmp;
    int          n_err;

    trap_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INT_W  (INT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .int_flag_i      (int_flag_i),
        .ecall_i         (ecall_i),
        .ebreak_i        (ebreak_i),
        .mret_i          (mret_i),
        .inst_addr_i     (inst_addr_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .ex_csr_we_i     (ex_csr_we_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .global_int_en_i (global_int_en_i),
        .hold_o          (hold_o),
        .csr_we_o        (csr_we_o),
        .csr_waddr_o     (csr_waddr_o),
        .csr_wdata_o     (csr_wdata_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
        logic [31:0] t;
        t = mtvec & ~32'h3;
`ifdef TRAP_CTRL_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && cause[31]) t = t + 4 * (cause & 32'h7FFF_FFFF);
`endif
        return t;
    endfunction

    // Reference model: each accepted request expands into a queue of steps; a write step is
    // consumed only when EX is not writing a CSR in the same cycle.
    always @(negedge clk) begin
        logic        e_hold, e_we, e_as;
        logic [31:0] e_waddr, e_wdata, e_iaddr;
        int          k;
        e_hold = 0; e_we = 0; e_as = 0; e_waddr = 0; e_wdata = 0; e_iaddr = 0;
        if (rst) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (ecall_i || ebreak_i) begin
                e_hold  = 1;
                m_epc   = inst_addr_i;
                m_cause = ecall_i ? 32'd11 : 32'd3;
                q       = '{K_MEPC, K_MST_T, K_MCAUS, K_AS_T};
            end else if (mret_i) begin
                e_hold = 1;
                q      = '{K_MST_R, K_AS_R};
            end else if (global_int_en_i && int_flag_i != 0) begin
                e_hold  = 1;
                m_epc   = jump_flag_i ? jump_addr_i : inst_addr_i;
                m_cause = 32'h8000_000B;
                q       = '{K_MEPC, K_MST_T, K_MCAUS, K_AS_T};
            end
        end else begin
            k      = q[0];
            e_hold = 1;
            case (k)
                K_MEPC: begin e_we = 1; e_waddr = 32'h341; e_wdata = m_epc; end
                K_MST_T: begin
                    e_we = 1; e_waddr = 32'h300;
                    e_wdata = (csr_mstatus_i & ~32'h88) | (csr_mstatus_i[3] ? 32'h80 : 32'h0);
                end
                K_MCAUS: begin e_we = 1; e_waddr = 32'h342; e_wdata = m_cause; end
                K_MST_R: begin
                    e_we = 1; e_waddr = 32'h300;
                    e_wdata = (csr_mstatus_i & ~32'h08) | 32'h80 | (csr_mstatus_i[7] ? 32'h8 : 32'h0);
                end
                K_AS_T: begin e_as = 1; e_iaddr = trap_target(csr_mtvec_i, m_cause); end
                default: begin e_as = 1; e_iaddr = csr_mepc_i; end
            endcase
            if (!(e_we && ex_csr_we_i)) begin
                if (e_we && e_waddr == 32'h341) m_mepc = e_wdata;
                if (e_we && e_waddr == 32'h300) m_mstatus = e_wdata;
                void'(q.pop_front());
            end
        end
        chk("hold_o", {31'b0, hold_o}, {31'b0, e_hold});
        chk("csr_we_o", {31'b0, csr_we_o}, {31'b0, e_we});
        chk("csr_waddr_o", csr_waddr_o, e_waddr);
        chk("csr_wdata_o", csr_wdata_o, e_wdata);
        chk("int_assert_o", {31'b0, int_assert_o}, {31'b0, e_as});
        chk("int_addr_o", int_addr_o, e_iaddr);
    end

    task automatic load_csr();
        csr_mtvec_i     = m_mtvec;
        csr_mepc_i      = m_mepc;
        csr_mstatus_i   = m_mstatus;
        global_int_en_i = m_mstatus[3];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        load_csr();
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1; int_flag_i = 0; ecall_i = 0; ebreak_i = 0; mret_i = 0;
        inst_addr_i = 0; jump_flag_i = 0; jump_addr_i = 0; ex_csr_we_i = 0;
        m_mtvec = 0; m_mepc = 0; m_mstatus = 0; m_epc = 0; m_cause = 0;
        load_csr();
        next_cycle();
        ecall_i = 1;
        wait_neg();
        chk("rst_hold", {31'b0, hold_o}, 32'd0);
        chk("rst_we", {31'b0, csr_we_o}, 32'd0);
        next_cycle(); rst = 0; ecall_i = 0;
        wait_neg();
        chk("idle_assert", {31'b0, int_assert_o}, 32'd0);

        // ecall at 0x80, mtvec 0x100
        next_cycle();
        m_mtvec = 32'h100; m_mstatus = 32'h8; load_csr();
        ecall_i = 1; inst_addr_i = 32'h80;
        wait_neg(); chk("t1_c0_hold", {31'b0, hold_o}, 32'd1);
        next_cycle(); ecall_i = 0;
        wait_neg(); chk("t1_mepc_addr", csr_waddr_o, 32'h341); chk("t1_mepc_data", csr_wdata_o, 32'h80);
        next_cycle();
        wait_neg(); chk("t1_mst_addr", csr_waddr_o, 32'h300); chk("t1_mst_data", csr_wdata_o, 32'h80);
        next_cycle();
        wait_neg(); chk("t1_mcause_addr", csr_waddr_o, 32'h342); chk("t1_mcause_data", csr_wdata_o, 32'd11);
        next_cycle();
        wait_neg(); chk("t1_assert", {31'b0, int_assert_o}, 32'd1); chk("t1_addr", int_addr_o, 32'h100);
        chk("t1_c4_hold", {31'b0, hold_o}, 32'd1);
        next_cycle();
        wait_neg(); chk("t1_c5_hold", {31'b0, hold_o}, 32'd0);

        // mret with mepc 0x84, mstatus 0x80
        next_cycle();
        m_mepc = 32'h84; m_mstatus = 32'h80; load_csr(); mret_i = 1;
        wait_neg(); chk("t3_hold", {31'b0, hold_o}, 32'd1);
        next_cycle(); mret_i = 0;
        wait_neg(); chk("t3_mst_addr", csr_waddr_o, 32'h300); chk("t3_mst_data", csr_wdata_o, 32'h88);
        next_cycle();
        wait_neg(); chk("t3_assert", {31'b0, int_assert_o}, 32'd1); chk("t3_addr", int_addr_o, 32'h84);

        // interrupt while EX redirects to 0x200
        next_cycle();
        int_flag_i = 8'h01; jump_flag_i = 1; jump_addr_i = 32'h200; inst_addr_i = 32'h90;
        wait_neg(); chk("t2_hold", {31'b0, hold_o}, 32'd1);
        next_cycle(); int_flag_i = 0; jump_flag_i = 0;
        wait_neg(); chk("t2_mepc", csr_wdata_o, 32'h200);
        next_cycle();
        wait_neg(); chk("t2_mstatus", csr_wdata_o, 32'h80);
        next_cycle();
        wait_neg(); chk("t2_mcause", csr_wdata_o, 32'h8000_000B);
        next_cycle();
        wait_neg(); chk("t2_addr", int_addr_o, 32'h100);
        next_cycle(); int_flag_i = 8'h01;
        wait_neg(); chk("t2_mie0_hold", {31'b0, hold_o}, 32'd0);
        next_cycle();
        wait_neg(); chk("t2_mie0_we", {31'b0, csr_we_o}, 32'd0);
        int_flag_i = 0;

        // EX CSR write collides with W_MSTATUS
        next_cycle(); ecall_i = 1; inst_addr_i = 32'h40;
        wait_neg();
        next_cycle(); ecall_i = 0;
        wait_neg(); chk("t4_mepc", csr_waddr_o, 32'h341);
        next_cycle(); ex_csr_we_i = 1;
        wait_neg(); chk("t4_mst1", csr_waddr_o, 32'h300);
        next_cycle(); ex_csr_we_i = 0;
        wait_neg(); chk("t4_mst2", csr_waddr_o, 32'h300);
        next_cycle();
        wait_neg(); chk("t4_mcause", csr_waddr_o, 32'h342);
        next_cycle();
        wait_neg(); chk("t4_assert", {31'b0, int_assert_o}, 32'd1);

        // rst during W_MCAUSE
        next_cycle(); ebreak_i = 1; inst_addr_i = 32'h44;
        next_cycle(); ebreak_i = 0;
        next_cycle();
        next_cycle(); rst = 1;
        wait_neg(); chk("t5_rst_we", {31'b0, csr_we_o}, 32'd0);
        next_cycle(); rst = 0;
        wait_neg(); chk("t5_hold", {31'b0, hold_o}, 32'd0); chk("t5_we", {31'b0, csr_we_o}, 32'd0);
        chk("t5_assert", {31'b0, int_assert_o}, 32'd0);

        // mtvec mode 01: vectored interrupt only when the option is built in
        next_cycle();
        m_mtvec = 32'h101; m_mstatus = 32'h8; load_csr(); int_flag_i = 8'h04;
        next_cycle(); int_flag_i = 0;
        repeat (3) next_cycle();
        wait_neg();
`ifdef TRAP_CTRL_VECTORED_EN
        chk("t6_int_addr", int_addr_o, 32'h12C);
`else
        chk("t6_int_addr", int_addr_o, 32'h100);
`endif
        next_cycle(); ecall_i = 1;
        next_cycle(); ecall_i = 0;
        repeat (3) next_cycle();
        wait_neg(); chk("t6_ecall_addr", int_addr_o, 32'h100);

        for (int i = 0; i < 3000; i++) begin
            int r;
            next_cycle();
            r           = int'($urandom_range(0, 15));
            ecall_i     = (r == 0);
            ebreak_i    = (r == 1);
            mret_i      = (r == 2);
            int_flag_i  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            jump_flag_i = 1'($urandom_range(0, 1));
            inst_addr_i = $urandom & 32'hFFFF_FFFC;
            jump_addr_i = $urandom & 32'hFFFF_FFFC;
            ex_csr_we_i = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 31) == 0) m_mstatus = m_mstatus ^ 32'h8;
            if ($urandom_range(0, 63) == 0)
                m_mtvec = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
            load_csr();
        end
        next_cycle();
        rst = 0; ecall_i = 0; ebreak_i = 0; mret_i = 0; int_flag_i = 0; ex_csr_we_i = 0;
        repeat (8) next_cycle();
        wait_neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
